// File: rtl/ex_mem_stage_pkg.sv
// Shared widths and payload bit layout for the EX/MEM pipeline register.
// Payload packing, MSB to LSB: result, store_data, rd, reg_write, mem_read, mem_write.
package ex_mem_stage_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;

   function automatic int payload_w(input int data_w, input int reg_addr_w);
      return 2 * data_w + reg_addr_w + 3;
   endfunction

   localparam int MEM_WRITE_BIT = 0;
   localparam int MEM_READ_BIT  = 1;
   localparam int REG_WRITE_BIT = 2;
   localparam int RD_LSB        = 3;

   function automatic int store_lsb(input int reg_addr_w);
      return RD_LSB + reg_addr_w;
   endfunction

   function automatic int result_lsb(input int data_w, input int reg_addr_w);
      return store_lsb(reg_addr_w) + data_w;
   endfunction

   localparam int PAYLOAD_W  = payload_w(DEF_DATA_W, DEF_REG_ADDR_W);
   localparam int STORE_LSB  = store_lsb(DEF_REG_ADDR_W);
   localparam int RESULT_LSB = result_lsb(DEF_DATA_W, DEF_REG_ADDR_W);

endpackage

// File: rtl/ex_mem_stage_if.sv
// One valid/ready channel carrying an execute-stage op and its control payload.
interface ex_mem_stage_if
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

   logic                  valid;
   logic                  ready;
   logic [DATA_W-1:0]     result;
   logic [DATA_W-1:0]     store_data;
   logic [REG_ADDR_W-1:0] rd;
   logic                  reg_write;
   logic                  mem_read;
   logic                  mem_write;
   logic                  cond_move;
   logic                  movn;

   modport master (
      output valid, result, store_data, rd, reg_write, mem_read, mem_write, cond_move, movn,
      input  ready
   );

   modport slave (
      input  valid, result, store_data, rd, reg_write, mem_read, mem_write, cond_move, movn,
      output ready
   );

endinterface

// File: rtl/ex_mem_stage_pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with flush. Ready depends only on
// registered state, so there is no combinational path from out_ready to in_ready.
module pipe_skid_buffer
   import ex_mem_stage_pkg::*;
#(
   parameter int PAYLOAD_W = ex_mem_stage_pkg::PAYLOAD_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data
);

   logic                 head_valid;
   logic                 skid_valid;
   logic [PAYLOAD_W-1:0] head_data;
   logic [PAYLOAD_W-1:0] skid_data;
   logic                 accept;
   logic                 head_free;

   assign in_ready  = !skid_valid && !reset;
   assign accept    = in_valid && in_ready && !flush;
   assign head_free = !head_valid || out_ready;

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values; the payload is reset too so outputs read 0 in reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
         head_data  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (head_free) begin
         if (skid_valid) begin
            head_data  <= skid_data;
            head_valid <= 1'b1;
            skid_valid <= accept;
            if (accept) skid_data <= in_data;
         end else begin
            head_valid <= accept;
            if (accept) head_data <= in_data;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

   assign out_valid = head_valid;
   assign out_data  = head_data;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves the register write enable at capture,
// buffers ops through a skid buffer and exposes the head as a forwarding source.
// Optional macro COND_MOVE_EN compiles in MOVZ/MOVN write-enable resolution.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   ex_mem_stage_if.slave         ex,
   ex_mem_stage_if.master        mem,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0]     fwd_result
);

   localparam int PW     = payload_w(DATA_W, REG_ADDR_W);
   localparam int ST_LSB = store_lsb(REG_ADDR_W);
   localparam int RS_LSB = result_lsb(DATA_W, REG_ADDR_W);

   logic          cmove_ok;
   logic          reg_write_res;
   logic [PW-1:0] in_data;
   logic [PW-1:0] head_data;
   logic          head_valid;

`ifdef COND_MOVE_EN
   always_comb begin
      cmove_ok = 1'b1;
      if (ex.cond_move) cmove_ok = ex.movn ? (|ex.store_data) : ~(|ex.store_data);
   end
`else
   logic unused_cmove;
   assign unused_cmove = ex.cond_move ^ ex.movn;
   assign cmove_ok     = 1'b1;
`endif

   // Writes to $zero are dropped here so the memory stage never sees them.
   assign reg_write_res = ex.reg_write && cmove_ok && (|ex.rd);

   assign in_data = {ex.result, ex.store_data, ex.rd, reg_write_res, ex.mem_read, ex.mem_write};

   pipe_skid_buffer #(.PAYLOAD_W(PW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (ex.valid),
      .in_ready  (ex.ready),
      .in_data   (in_data),
      .out_valid (head_valid),
      .out_ready (mem.ready),
      .out_data  (head_data)
   );

   assign mem.valid      = head_valid;
   assign mem.result     = head_data[RS_LSB +: DATA_W];
   assign mem.store_data = head_data[ST_LSB +: DATA_W];
   assign mem.rd         = head_data[RD_LSB +: REG_ADDR_W];
   assign mem.reg_write  = head_data[REG_WRITE_BIT];
   assign mem.mem_read   = head_data[MEM_READ_BIT];
   assign mem.mem_write  = head_data[MEM_WRITE_BIT];
   assign mem.cond_move  = 1'b0;
   assign mem.movn       = 1'b0;

   assign fwd_valid  = head_valid && head_data[REG_WRITE_BIT];
   assign fwd_rd     = head_data[RD_LSB +: REG_ADDR_W];
   assign fwd_result = head_data[RS_LSB +: DATA_W];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared against a 2-deep FIFO reference model.
module tb_ex_mem_stage;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        cond_move;
      logic        movn;
   } op_t;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_result;

   int n_checks = 0;
   int n_fail   = 0;
   entry_t exp_q[$];

   ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) ex_if ();
   ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) mem_if ();

   ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .ex         (ex_if),
      .mem        (mem_if),
      .fwd_valid  (fwd_valid),
      .fwd_rd     (fwd_rd),
      .fwd_result (fwd_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic entry_t to_entry(input op_t op);
      entry_t e;
      bit     we;
      we = op.reg_write && (op.rd != 5'd0);
`ifdef COND_MOVE_EN
      if (op.cond_move) we = we && (op.movn ? (op.store_data != 32'd0) : (op.store_data == 32'd0));
`endif
      e.result     = op.result;
      e.store_data = op.store_data;
      e.rd         = op.rd;
      e.reg_write  = we;
      e.mem_read   = op.mem_read;
      e.mem_write  = op.mem_write;
      return e;
   endfunction

   function automatic op_t mk(input logic [31:0] res, input logic [31:0] st, input logic [4:0] rd,
                              input bit rw, input bit mr, input bit mw, input bit cm, input bit mn);
      op_t o;
      o.result = res; o.store_data = st; o.rd = rd; o.reg_write = rw;
      o.mem_read = mr; o.mem_write = mw; o.cond_move = cm; o.movn = mn;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.result     = $urandom;
      o.store_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      o.rd         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      o.reg_write  = 1'($urandom);
      o.mem_read   = 1'($urandom);
      o.mem_write  = 1'($urandom);
      o.cond_move  = 1'($urandom);
      o.movn       = 1'($urandom);
      return o;
   endfunction

   task automatic check_outputs();
      entry_t h;
      check("ex_ready", ex_if.ready, !reset && (exp_q.size() < 2));
      check("mem_valid", mem_if.valid, exp_q.size() > 0);
      if (reset) begin
         check("rst_result", mem_if.result, 0);
         check("rst_store", mem_if.store_data, 0);
         check("rst_ctrl", {mem_if.rd, mem_if.reg_write, mem_if.mem_read, mem_if.mem_write}, 0);
         check("rst_fwd", {fwd_valid, fwd_rd, fwd_result}, 0);
      end else if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("mem_result", mem_if.result, h.result);
         check("mem_store_data", mem_if.store_data, h.store_data);
         check("mem_rd", mem_if.rd, h.rd);
         check("mem_reg_write", mem_if.reg_write, h.reg_write);
         check("mem_flags", {mem_if.mem_read, mem_if.mem_write}, {h.mem_read, h.mem_write});
         check("fwd_valid", fwd_valid, h.reg_write);
         check("fwd_rd", fwd_rd, h.rd);
         check("fwd_result", fwd_result, h.result);
      end else begin
         check("fwd_valid_idle", fwd_valid, 0);
      end
   endtask

   // One clock: check the state left by the previous edge, then apply inputs
   // and advance the reference FIFO to what the coming edge should produce.
   task automatic cycle(input bit rst, input bit fl, input bit v, input bit rdy, input op_t op);
      bit acc;
      @(negedge clk);
      check_outputs();
      reset                = rst;
      flush                = fl;
      ex_if.valid          = v;
      ex_if.result         = op.result;
      ex_if.store_data     = op.store_data;
      ex_if.rd             = op.rd;
      ex_if.reg_write      = op.reg_write;
      ex_if.mem_read       = op.mem_read;
      ex_if.mem_write      = op.mem_write;
      ex_if.cond_move      = op.cond_move;
      ex_if.movn           = op.movn;
      mem_if.ready         = rdy;
      if (rst || fl) begin
         exp_q.delete();
      end else begin
         acc = v && (exp_q.size() < 2);
         if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(to_entry(op));
      end
   endtask

   op_t idle;

   initial begin
      idle = mk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
      ex_if.valid = 1'b1;
      ex_if.result = 32'h1234_5678; ex_if.store_data = 32'h9; ex_if.rd = 5'd7;
      ex_if.reg_write = 1'b1; ex_if.mem_read = 1'b1; ex_if.mem_write = 1'b1;
      ex_if.cond_move = 1'b0; ex_if.movn = 1'b0;
      mem_if.ready = 1'b0;

      // Reset held with an op presented.
      cycle(1, 0, 1, 0, mk(32'h1234_5678, 32'h9, 5'd7, 1, 1, 1, 0, 0));
      cycle(1, 0, 1, 0, mk(32'h1234_5678, 32'h9, 5'd7, 1, 1, 1, 0, 0));
      cycle(0, 0, 0, 0, idle);

      // Unstalled stream.
      cycle(0, 0, 1, 1, mk(32'h1, 32'h0, 5'd1, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 1, mk(32'h0, 32'h0, 5'd2, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 1, mk(32'h1F, 32'h0, 5'd3, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 1, mk(32'h20, 32'h0, 5'd4, 1, 0, 0, 0, 0));
      cycle(0, 0, 0, 1, idle);

      // Backpressure: A, B captured, C held by execute until space frees.
      cycle(0, 0, 1, 0, mk(32'hA, 32'h0, 5'd10, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 0, mk(32'hB, 32'h0, 5'd11, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 0, mk(32'hC, 32'h0, 5'd12, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 1, mk(32'hC, 32'h0, 5'd12, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 1, mk(32'hC, 32'h0, 5'd12, 1, 0, 0, 0, 0));
      cycle(0, 0, 0, 1, idle);
      cycle(0, 0, 0, 1, idle);

      // Conditional moves and $zero suppression.
      cycle(0, 0, 1, 1, mk(32'h11, 32'h0, 5'd8, 1, 0, 0, 1, 0));
      cycle(0, 0, 1, 1, mk(32'h22, 32'h5, 5'd8, 1, 0, 0, 1, 0));
      cycle(0, 0, 1, 1, mk(32'h33, 32'h5, 5'd8, 1, 0, 0, 1, 1));
      cycle(0, 0, 1, 1, mk(32'h44, 32'h0, 5'd8, 1, 0, 0, 1, 1));
      cycle(0, 0, 1, 1, mk(32'h55, 32'h7, 5'd0, 1, 0, 0, 0, 0));
      cycle(0, 0, 0, 1, idle);

      // Fill head and skid, then flush with an op presented.
      cycle(0, 0, 1, 0, mk(32'hF1, 32'h0, 5'd5, 1, 0, 0, 0, 0));
      cycle(0, 0, 1, 0, mk(32'hF2, 32'h0, 5'd6, 1, 0, 0, 0, 0));
      cycle(0, 1, 1, 0, mk(32'hF3, 32'h0, 5'd7, 1, 0, 0, 0, 0));
      cycle(0, 0, 0, 1, idle);
      cycle(0, 0, 0, 1, idle);

      // Forwarding source: register-writing op, then a store.
      cycle(0, 0, 1, 0, mk(32'hDEAD_BEEF, 32'h0, 5'd3, 1, 0, 0, 0, 0));
      cycle(0, 0, 0, 1, idle);
      cycle(0, 0, 1, 0, mk(32'h100, 32'hCAFE, 5'd9, 0, 0, 1, 0, 0));
      cycle(0, 0, 0, 1, idle);
      cycle(0, 0, 0, 1, idle);

      // Random traffic, with occasional flush and reset.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
               1'($urandom), ($urandom_range(0, 3) != 0), rand_op());
      end
      cycle(0, 0, 0, 1, idle);
      cycle(0, 0, 0, 1, idle);
      @(negedge clk);
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
